dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Shares the 16×4 data memory between the processor core and an external host/debug port, one clock domain. The core has fixed priority. The host gets idle memory cycles. If the host waits too long, the arbiter holds the core for one cycle and forces a host access. It sits between `computational_unit`/`instruction_decoder` and `data_memory`, and drives the memory's address, data and write-enable inputs.

## Interface
- `STARVE_LIMIT`, 4: host wait cycles before a forced access; legal range 1..15.
- `ADDR_W`, 4: memory address width.
- `DATA_W`, 4: memory word width.
- `clk` in 1: system clock; all state changes on posedge.
- `reset_n` in 1: reset is synchronous and active-low.
- `cpu_active` in 1: core uses data memory this cycle (read or write).
- `cpu_addr` in ADDR_W: core address (`i` register).
- `cpu_wdata` in DATA_W: core write data (data bus).
- `cpu_wren` in 1: core write enable (`register_enables[7]`).
- `cpu_hold` out 1: registered; core must not access memory while high.
- `host_req` in 1: host request, level, held until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read; stable while `host_req` is high.
- `host_addr` in ADDR_W: host address; stable while `host_req` is high.
- `host_wdata` in DATA_W: host write data; stable while `host_req` is high.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out DATA_W: read result; valid with `host_ack`, held until the next ack.
- `mem_addr` out ADDR_W: to `data_memory` address.
- `mem_data` out DATA_W: to `data_memory` data.
- `mem_wren` out 1: to `data_memory` write enable.
- `mem_q` in DATA_W: `data_memory` read data; valid at the end of the access cycle (memory clocked on ~clk).
- `host_grant` out 1: combinational; host owns memory this cycle.
- `force_count` out 8: saturating count of forced accesses.
- `conflict_err` out 1: sticky; the core accessed memory while `cpu_hold` was high.

## Operation
- FSM states: IDLE, WAIT, FORCE, DONE.
- IDLE → WAIT when `host_req`=1. `wait_cnt` ← 0.
- WAIT, `cpu_active`=0: `host_grant`=1, access performed, go to DONE.
- WAIT, `cpu_active`=1: `wait_cnt`++. When `wait_cnt`==STARVE_LIMIT−1, go to FORCE and register `cpu_hold`=1.
- FORCE: `cpu_hold`=1 and `host_grant`=1 unconditionally. Go to DONE. `force_count` increments, saturating at 255.
- DONE: `host_ack`=1. `cpu_hold`=0. Go to IDLE.
- Memory mux when `host_grant`=1: `mem_addr`=`host_addr`, `mem_data`=`host_wdata`, `mem_wren`=`host_we`.
- Memory mux otherwise: `mem_addr`=`cpu_addr`, `mem_data`=`cpu_wdata`, `mem_wren`=`cpu_wren`.
- In FORCE, the core write is dropped even if `cpu_wren`=1. If `cpu_active`=1 in that cycle, `conflict_err` ← 1.
- Read data: at the posedge that ends a granted cycle with `host_we`=0, `host_rdata` ← `mem_q`. `host_rdata` is unchanged by host writes.
- Host must drop `host_req` at the edge ending the ack cycle. A `host_req` still high in IDLE is a new request.

## Timing
- Reset (`reset_n`=0 at a posedge) drives:
  - state to IDLE, `wait_cnt` to 0;
  - `cpu_hold`, `host_ack`, `conflict_err` to 0;
  - `host_rdata` to 0, `force_count` to 0.
- Reset mid-transaction abandons the access with no ack. An in-flight host write may already have landed.
- Best-case latency: `host_req` rises in cycle 0, grant in cycle 1, `host_ack` in cycle 2.
- Starved latency: grant in cycle STARVE_LIMIT+1 (FORCE), `host_ack` in cycle STARVE_LIMIT+2.
- `cpu_hold` is high exactly one cycle per forced access (the FORCE cycle).
- Simultaneous core and host access in WAIT: the core wins unless the state is FORCE.
- STARVE_LIMIT=1: WAIT with `cpu_active`=1 goes straight to FORCE next cycle.

## Structure
- Package `dm_arb_pkg`: `arb_state_t` enum (IDLE/WAIT/FORCE/DONE), `FORCE_CNT_W`=8, default widths.
- Sub-module `sat_counter`: parameterised width, increment with saturation, synchronous active-low clear. Used for `force_count`.
- Memory mux stays combinational inside `dm_arbiter`.

## Test plan
- Idle core: host write addr 3 data 0xA, then host read addr 3 → ack at +2 cycles each, `host_rdata`=0xA, `cpu_hold` never high.
- Core busy 2 cycles, STARVE_LIMIT=4, host read → grant on first idle cycle, ack 4 cycles after req, `force_count`=0.
- Core busy continuously, STARVE_LIMIT=4 → `cpu_hold` high in cycle 5 only, ack in cycle 6, `force_count`=1, core write in cycle 5 not in memory.
- Core asserts `cpu_active` during `cpu_hold` → `conflict_err`=1, stays 1 until `reset_n`=0.
- `reset_n` low while in WAIT → next cycle IDLE, no ack, all outputs at reset values; 300 forced accesses → `force_count`=255.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int FORCE_CNT_W = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 4;

endpackage

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: core has priority, host takes idle cycles, and a
// starved host forces one access by holding the core for a single cycle.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_active,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    input  logic                   cpu_wren,
    output logic                   cpu_hold,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ack,
    output logic [DATA_W-1:0]      host_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_wren,
    input  logic [DATA_W-1:0]      mem_q,
    output logic                   host_grant,
    output logic [FORCE_CNT_W-1:0] force_count,
    output logic                   conflict_err
);

    localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);

    arb_state_t        state_q;
    logic [3:0]        wait_cnt_q;
    logic              cpu_hold_q;
    logic              host_ack_q;
    logic              conflict_q;
    logic [DATA_W-1:0] host_rdata_q;

    // In WAIT the core still wins; only FORCE overrides it.
    assign host_grant = (state_q == FORCE) || ((state_q == WAIT) && !cpu_active);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            cpu_hold_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            conflict_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_ack_q <= 1'b0;
            if (host_grant && !host_we) begin
                host_rdata_q <= mem_q;
            end
            case (state_q)
                IDLE: begin
                    if (host_req) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (!cpu_active) begin
                        state_q    <= DONE;
                        host_ack_q <= 1'b1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= FORCE;
                        cpu_hold_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                FORCE: begin
                    state_q    <= DONE;
                    host_ack_q <= 1'b1;
                    cpu_hold_q <= 1'b0;
                    if (cpu_active) begin
                        conflict_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Core write in the FORCE cycle is dropped because the host owns the mux.
    assign mem_addr = host_grant ? host_addr  : cpu_addr;
    assign mem_data = host_grant ? host_wdata : cpu_wdata;
    assign mem_wren = host_grant ? host_we    : cpu_wren;

    sat_counter #(
        .W (FORCE_CNT_W)
    ) u_force_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .inc     (state_q == FORCE),
        .count   (force_count)
    );

    assign cpu_hold     = cpu_hold_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign conflict_err = conflict_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory and a
// scoreboard of expected ack latency / read data per host transaction.
module tb_dm_arbiter;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_active, cpu_wren, cpu_hold;
    logic [3:0] cpu_addr, cpu_wdata;
    logic       host_req, host_we, host_ack, host_grant;
    logic [3:0] host_addr, host_wdata, host_rdata;
    logic [3:0] mem_addr, mem_data, mem_q;
    logic       mem_wren, conflict_err;
    logic [7:0] force_count;

    dm_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(4), .DATA_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_active(cpu_active), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wren(cpu_wren), .cpu_hold(cpu_hold),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .host_grant(host_grant), .force_count(force_count),
        .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    // Behavioural data memory, clocked on the falling edge.
    logic [3:0] mem [16];
    always @(negedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    typedef struct {
        logic [3:0] rdata;
        int         ack_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] shadow [16];
    logic [3:0] exp_rdata;
    int         exp_force;
    logic       exp_conflict;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One host transaction; the core is busy in cycles 1..busy after the request.
    task automatic txn(input logic we, input logic [3:0] addr, input logic [3:0] wdata,
                       input int busy, input logic core_wr);
        int   g;
        bit   forced;
        bit   acked;
        exp_t e;
        forced    = (busy >= LIMIT);
        g         = forced ? LIMIT + 1 : busy + 1;
        e.ack_cyc = g + 1;
        e.rdata   = we ? exp_rdata : shadow[addr];
        exp_rdata = e.rdata;
        sb.push_back(e);
        acked      = 1'b0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        for (int cyc = 0; cyc < 30 && !acked; cyc++) begin
            if (cyc > 0) tick();
            cpu_active = (cyc >= 1) && (cyc <= busy);
            cpu_wren   = core_wr && cpu_active;
            cpu_addr   = 4'h5;
            cpu_wdata  = 4'(cyc);
            #1;
            chk("grant", {31'd0, host_grant}, {31'd0, cyc == g});
            chk("hold", {31'd0, cpu_hold}, {31'd0, forced && (cyc == g)});
            if (cyc == g) chk("mem_wren", {31'd0, mem_wren}, {31'd0, we});
            if (cpu_wren && cyc != g) shadow[5] = 4'(cyc);
            if (cyc == g && we) shadow[addr] = wdata;
            if (forced && cyc == g && cpu_active) exp_conflict = 1'b1;
            if (host_ack) begin
                acked = 1'b1;
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.ack_cyc);
                chk("rdata", {28'd0, host_rdata}, {28'd0, e.rdata});
            end
        end
        if (!acked) begin
            vectors++;
            miscompares++;
            $error("FAIL ack_timeout: observed no ack expected ack in cycle %0d", g + 1);
            void'(sb.pop_front());
        end
        if (forced) exp_force = (exp_force >= 255) ? 255 : exp_force + 1;
        tick();
        host_req   = 1'b0;
        cpu_active = 1'b0;
        cpu_wren   = 1'b0;
        #1;
        chk("force_count", {24'd0, force_count}, exp_force);
        chk("conflict", {31'd0, conflict_err}, {31'd0, exp_conflict});
        chk("ack_low", {31'd0, host_ack}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hold"},     {31'd0, cpu_hold},     32'd0);
        chk({tag, "_ack"},      {31'd0, host_ack},     32'd0);
        chk({tag, "_conflict"}, {31'd0, conflict_err}, 32'd0);
        chk({tag, "_rdata"},    {28'd0, host_rdata},   32'd0);
        chk({tag, "_fcount"},   {24'd0, force_count},  32'd0);
        chk({tag, "_grant"},    {31'd0, host_grant},   32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 4'h0;
            shadow[i] = 4'h0;
        end
        reset_n    = 1'b0;
        cpu_active = 1'b0;
        cpu_wren   = 1'b0;
        cpu_addr   = 4'h0;
        cpu_wdata  = 4'h0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 4'h0;
        host_wdata = 4'h0;
        exp_rdata    = 4'h0;
        exp_force    = 0;
        exp_conflict = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Idle core: write then read back, two-cycle latency each.
        txn(1'b1, 4'h3, 4'hA, 0, 1'b0);
        txn(1'b0, 4'h3, 4'h0, 0, 1'b0);
        txn(1'b1, 4'h7, 4'h6, 0, 1'b0);

        // Core busy two cycles: host granted on the first idle cycle.
        txn(1'b0, 4'h7, 4'h0, 2, 1'b0);

        // Starved write with the core idle in the FORCE cycle.
        txn(1'b1, 4'h9, 4'hC, LIMIT, 1'b0);

        // Starved write with the core writing through the FORCE cycle.
        txn(1'b1, 4'h9, 4'h3, LIMIT + 1, 1'b1);
        txn(1'b0, 4'h5, 4'h0, 0, 1'b0);
        txn(1'b0, 4'h9, 4'h0, 1, 1'b0);

        // Reset while WAIT: request abandoned, everything back to reset values.
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 4'h3;
        cpu_active = 1'b1;
        tick();
        tick();
        reset_n    = 1'b0;
        host_req   = 1'b0;
        cpu_active = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        tick();
        chk("midreset_noack", {31'd0, host_ack}, 32'd0);
        exp_rdata    = 4'h0;
        exp_force    = 0;
        exp_conflict = 1'b0;

        // Saturation of the forced-access counter.
        for (int n = 0; n < 300; n++) begin
            txn(1'b0, 4'h3, 4'h0, LIMIT, 1'b0);
        end
        chk("fcount_sat", {24'd0, force_count}, 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
